// File: rtl/contador_ocupacion_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : contador_ocupacion_pkg
//  Purpose  : Shared encodings for the parking occupancy counter and the
//             upstream parking FSM, plus constant BCD digit helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package contador_ocupacion_pkg;

  // Width of every occupancy/free-space count (covers 0..99)
  localparam int unsigned CUENTA_W = 7;

  // Occupancy FSM states
  typedef enum logic [1:0] {
    VACIO      = 2'd0,
    DISPONIBLE = 2'd1,
    LLENO      = 2'd2,
    ERROR      = 2'd3
  } ocupacion_t;

  // Upstream parking (barrier) FSM states that produce entrada/salida
  typedef enum logic [2:0] {
    P_REPOSO     = 3'd0,
    P_ENTRANDO   = 3'd1,
    P_ESPERA_ENT = 3'd2,
    P_SALIENDO   = 3'd3,
    P_ESPERA_SAL = 3'd4
  } parking_t;

  // Tens digit of a constant, used for reset values only
  function automatic logic [3:0] decenas_de(input int unsigned v);
    return 4'(v / 10);
  endfunction

  // Units digit of a constant, used for reset values only
  function automatic logic [3:0] unidades_de(input int unsigned v);
    return 4'(v % 10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_a_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin_a_bcd
//  Purpose  : Combinational binary (0..99) to two-digit BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_a_bcd
  import contador_ocupacion_pkg::*;
(
  input  logic [CUENTA_W-1:0] bin,
  output logic [3:0]          dec,
  output logic [3:0]          uni
);

  logic [CUENTA_W-1:0] resto;

  // Repeated subtraction of ten; nine steps are enough for inputs up to 99
  always_comb begin
    resto = bin;
    dec   = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (resto >= 7'd10) begin
        resto = resto - 7'd10;
        dec   = dec + 4'd1;
      end
    end
    uni = 4'(resto);
  end

endmodule
`default_nettype wire

// File: rtl/contador_ocupacion.sv
`default_nettype none
// ============================================================================
//  Module   : contador_ocupacion
//  Purpose  : Parking occupancy counter with edge-detected entry/exit events,
//             saturating count, sticky error flag and BCD free-space digits.
//  Revision : 1.0 - initial release
// ============================================================================
module contador_ocupacion
  import contador_ocupacion_pkg::*;
#(
  parameter int CAPACIDAD = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                entrada,
  input  logic                salida,
  input  logic                clr_error,
  output logic [CUENTA_W-1:0] ocupados,
  output logic [CUENTA_W-1:0] libres,
  output logic                lleno,
  output logic                vacio,
  output logic                error,
  output logic [3:0]          bcd_dec,
  output logic [3:0]          bcd_uni
);

  localparam logic [CUENTA_W-1:0] CAP     = CUENTA_W'(CAPACIDAD);
  localparam logic [3:0]          RST_DEC = decenas_de(CAPACIDAD);
  localparam logic [3:0]          RST_UNI = unidades_de(CAPACIDAD);

  logic                entrada_q, salida_q;
  logic                armado;     // set after the first post-reset sample
  logic                ent_edge, sal_edge, suma, resta;
  ocupacion_t          state, state_next, ocup_next;
  logic [CUENTA_W-1:0] count_next, libres_next;
  logic                err_set, error_next;
  logic [3:0]          dec_next, uni_next;

  // Previous-sample registers; an input already high at reset release
  // is absorbed by the first sample because armado is still low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entrada_q <= 1'b0;
      salida_q  <= 1'b0;
      armado    <= 1'b0;
    end else begin
      entrada_q <= entrada;
      salida_q  <= salida;
      armado    <= 1'b1;
    end
  end

  assign ent_edge = armado & entrada & ~entrada_q;
  assign sal_edge = armado & salida  & ~salida_q;
  // Simultaneous events cancel out
  assign suma     = ent_edge & ~sal_edge;
  assign resta    = sal_edge & ~ent_edge;

  // Next count, error and state from the current occupancy state
  always_comb begin
    count_next = ocupados;
    err_set    = 1'b0;
    unique case (state)
      VACIO: begin
        if (suma)  count_next = ocupados + 7'd1;
        if (resta) err_set    = 1'b1;
      end
      DISPONIBLE: begin
        if (suma)  count_next = ocupados + 7'd1;
        if (resta) count_next = ocupados - 7'd1;
      end
      LLENO: begin
        if (suma)  err_set    = 1'b1;
        if (resta) count_next = ocupados - 7'd1;
      end
      ERROR: begin
        if (suma) begin
          if (ocupados == CAP) err_set    = 1'b1;
          else                 count_next = ocupados + 7'd1;
        end
        if (resta) begin
          if (ocupados == '0)  err_set    = 1'b1;
          else                 count_next = ocupados - 7'd1;
        end
      end
      default: count_next = ocupados;
    endcase

    // Clear wins over a new overflow/underflow in the same cycle
    error_next = ~clr_error & (error | err_set);

    if (count_next == '0)       ocup_next = VACIO;
    else if (count_next == CAP) ocup_next = LLENO;
    else                        ocup_next = DISPONIBLE;

    state_next  = error_next ? ERROR : ocup_next;
    libres_next = CAP - count_next;
  end

  bin_a_bcd u_bin_a_bcd (
    .bin (libres_next),
    .dec (dec_next),
    .uni (uni_next)
  );

  // State and all outputs register together so they change on one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= VACIO;
      ocupados <= '0;
      libres   <= CAP;
      lleno    <= 1'b0;
      vacio    <= 1'b1;
      error    <= 1'b0;
      bcd_dec  <= RST_DEC;
      bcd_uni  <= RST_UNI;
    end else begin
      state    <= state_next;
      ocupados <= count_next;
      libres   <= libres_next;
      lleno    <= (count_next == CAP);
      vacio    <= (count_next == '0);
      error    <= error_next;
      bcd_dec  <= dec_next;
      bcd_uni  <= uni_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_contador_ocupacion.sv
`default_nettype none
// ============================================================================
//  Module   : tb_contador_ocupacion
//  Purpose  : Directed self-checking bench for contador_ocupacion (CAPACIDAD=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_contador_ocupacion;

  logic       clk = 1'b0;
  logic       reset, entrada, salida, clr_error;
  logic [6:0] ocupados, libres;
  logic       lleno, vacio, error;
  logic [3:0] bcd_dec, bcd_uni;
  logic [24:0] obs;
  logic [24:0] exp_v;
  int vectors = 0;
  int miscompares = 0;

  // Observed outputs packed as {ocupados, libres, lleno, vacio, error, dec, uni}
  assign obs = {ocupados, libres, lleno, vacio, error, bcd_dec, bcd_uni};

  contador_ocupacion #(.CAPACIDAD(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .entrada   (entrada),
    .salida    (salida),
    .clr_error (clr_error),
    .ocupados  (ocupados),
    .libres    (libres),
    .lleno     (lleno),
    .vacio     (vacio),
    .error     (error),
    .bcd_dec   (bcd_dec),
    .bcd_uni   (bcd_uni)
  );

  always #5 clk = ~clk;

  // Compare the packed outputs against exp_v and report under a name
  task automatic compare(input string name);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got ocup=%0d libres=%0d lleno=%b vacio=%b error=%b bcd=%0d,%0d (raw %h) expected raw %h",
               name, ocupados, libres, lleno, vacio, error, bcd_dec, bcd_uni, obs, exp_v);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; entrada = 1'b0; salida = 1'b0; clr_error = 1'b0;
    repeat (2) @(negedge clk);
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("reset_held");
    reset = 1'b0;
    @(negedge clk);
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("reset_released");
  endtask

  task automatic test_entrada_larga;
    entrada = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = {7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
      compare($sformatf("long_high_%0d", i));
    end
    entrada = 1'b0;
    @(negedge clk);
    exp_v = {7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
    compare("long_released");
  endtask

  task automatic test_llenado;
    logic [24:0] tabla [3];
    tabla[0] = {7'd2, 7'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    tabla[1] = {7'd3, 7'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tabla[2] = {7'd3, 7'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0};
    for (int i = 0; i < 3; i++) begin
      entrada = 1'b1;
      @(negedge clk);
      exp_v = tabla[i];
      compare($sformatf("fill_pulse_%0d", i));
      entrada = 1'b0;
      @(negedge clk);
    end
    exp_v = tabla[2];
    compare("fill_overflow_hold");
  endtask

  task automatic test_simultaneo;
    // Leave the full state: error stays set, counting continues
    salida = 1'b1;
    @(negedge clk);
    salida = 1'b0;
    exp_v = {7'd2, 7'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    compare("exit_in_error");
    @(negedge clk);
    entrada = 1'b1; salida = 1'b1;
    @(negedge clk);
    entrada = 1'b0; salida = 1'b0;
    exp_v = {7'd2, 7'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    compare("simultaneous");
    @(negedge clk);
    // Event in the same cycle as clear is still counted
    salida = 1'b1; clr_error = 1'b1;
    @(negedge clk);
    salida = 1'b0; clr_error = 1'b0;
    exp_v = {7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
    compare("exit_with_clear");
    @(negedge clk);
  endtask

  task automatic test_underflow_clr;
    salida = 1'b1;
    @(negedge clk);
    salida = 1'b0;
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("exit_to_empty");
    @(negedge clk);
    salida = 1'b1;
    @(negedge clk);
    salida = 1'b0;
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3};
    compare("underflow");
    @(negedge clk);
    clr_error = 1'b1;
    @(negedge clk);
    clr_error = 1'b0;
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("clear_error");
    // Clear wins over a new underflow in the same cycle
    salida = 1'b1; clr_error = 1'b1;
    @(negedge clk);
    salida = 1'b0; clr_error = 1'b0;
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("clear_priority");
    // Normal counting resumes from the empty state
    entrada = 1'b1;
    @(negedge clk);
    entrada = 1'b0;
    exp_v = {7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
    compare("count_after_clear");
    @(negedge clk);
    entrada = 1'b1;
    @(negedge clk);
    entrada = 1'b0;
    exp_v = {7'd2, 7'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1};
    compare("second_after_clear");
  endtask

  task automatic test_reset_async;
    @(posedge clk);
    #2;
    reset = 1'b1; entrada = 1'b1;
    #1;
    exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
    compare("async_reset");
    @(negedge clk);
    reset = 1'b0;
    // Entrada high across reset release must not count
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = {7'd0, 7'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3};
      compare($sformatf("high_at_release_%0d", i));
    end
    entrada = 1'b0;
    @(negedge clk);
    entrada = 1'b1;
    @(negedge clk);
    entrada = 1'b0;
    exp_v = {7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
    compare("first_edge_after_release");
  endtask

  initial begin
    test_reset();
    test_entrada_larga();
    test_llenado();
    test_simultaneo();
    test_underflow_clr();
    test_reset_async();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/contador_ocupacion.md
CONTADOR_OCUPACION -- requirements
Module: contador_ocupacion

Interface
REQ-001 SHALL have parameter CAPACIDAD, default 20, meaning total parking spaces; legal range 1..99.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port entrada  input  1  car-entered indication from the upstream parking FSM; may stay high more than one cycle.
REQ-005 SHALL have port salida  input  1  car-left indication from the upstream parking FSM; may stay high more than one cycle.
REQ-006 SHALL have port clr_error  input  1  synchronous clear of the sticky error flag.
REQ-007 SHALL have port ocupados  output  7  occupied-space count, binary.
REQ-008 SHALL have port libres  output  7  free-space count, always equal to CAPACIDAD - ocupados.
REQ-009 SHALL have port lleno  output  1  high when ocupados == CAPACIDAD.
REQ-010 SHALL have port vacio  output  1  high when ocupados == 0.
REQ-011 SHALL have port error  output  1  sticky flag for an overflow or underflow attempt.
REQ-012 SHALL have ports bcd_dec and bcd_uni  output  4 each  tens and units BCD digits of libres, for the entrance display.

Function
REQ-013 SHALL register entrada and salida once and count only rising edges (input high, previous sample low), so each event counts once regardless of pulse length.
REQ-014 SHALL update all outputs at the same clock edge that samples the rising edge; latency is one edge, with no combinational path from inputs to outputs.
REQ-015 SHALL implement a 4-state FSM: VACIO (ocupados==0), DISPONIBLE (0<ocupados<CAPACIDAD), LLENO (ocupados==CAPACIDAD), ERROR.
REQ-016 SHALL treat an entrada edge as follows: in VACIO or DISPONIBLE, add 1 and go to DISPONIBLE, or to LLENO if the new count equals CAPACIDAD; in LLENO, leave the count unchanged, set error, and go to ERROR.
REQ-017 SHALL treat a salida edge as follows: in LLENO or DISPONIBLE, subtract 1 and go to DISPONIBLE, or to VACIO if the new count is 0; in VACIO, leave the count unchanged, set error, and go to ERROR.
REQ-018 SHALL treat simultaneous entrada and salida edges in the same cycle as net zero: count, state and error all unchanged.
REQ-019 SHALL keep counting in ERROR with the same saturation rules, holding error=1 throughout.
REQ-020 SHALL, on clr_error=1, clear error and move from ERROR to the occupancy state that matches the current count.
REQ-021 SHALL let an event edge arriving in the same cycle as clr_error still be applied to the count; clr_error has priority over setting error in that cycle.
REQ-022 SHALL never wrap the count; the legal range is 0..CAPACIDAD.
REQ-023 SHALL register bcd_dec and bcd_uni from the next value of libres, so they are always consistent with libres in the same cycle.

Reset
REQ-024 SHALL, on reset=1 and at any time including mid-event, immediately set: ocupados=0, libres=CAPACIDAD, vacio=1, lleno=0, error=0, state=VACIO, edge-detect registers=0, and BCD outputs = digits of CAPACIDAD.
REQ-025 SHALL, if entrada is already high when reset is released, not count it; an edge needs a low sample after reset first.

Structure
REQ-026 SHALL place the state encoding constants (VACIO, DISPONIBLE, LLENO, ERROR) in a shared package, together with the parking FSM encodings.
REQ-027 SHALL implement the binary-to-BCD conversion (0..99) in one combinational sub-module, bin_a_bcd.
REQ-028 SHALL keep the edge detection, FSM and counter in contador_ocupacion itself.

Verification (CAPACIDAD=3, 10 ns clock, reset held 2 cycles)
REQ-029 Release reset -> ocupados=0, libres=3, vacio=1, bcd_dec=0, bcd_uni=3, error=0.
REQ-030 entrada held high 4 cycles, then low -> ocupados=1 (counted once), vacio=0, libres=2.
REQ-031 Three more single entrada pulses -> after the 2nd pulse lleno=1 and ocupados=3; the 3rd pulse gives error=1, ocupados stays 3.
REQ-032 entrada and salida rising in the same cycle while ocupados=2 -> ocupados stays 2, error unchanged.
REQ-033 From ocupados=0, one salida pulse -> error=1, ocupados=0; then clr_error for 1 cycle -> error=0, state VACIO.
REQ-034 Reset asserted between clock edges while ocupados=2 -> outputs return to REQ-024 values without waiting for a clock edge.
